// File: rtl/guess_round_ctrl.sv
// Round sequencer for the number-guessing game: latches secret and budget, compares guesses, drives status text.
// Optional build macro GUESS_HINT_EN adds the magnitude compare and TOO HIGH / TOO LOW hints.
module guess_round_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             submit_N,
  input  logic             submit_M,
  input  logic             button,
  input  logic [3:0]       timesIN,
  input  logic [WIDTH:0]   data_buffer,
  output logic [16*8:1]    string_o,
  output logic [2:0]       state,
  output logic [3:0]       attempts_left,
  output logic             win,
  output logic             lose
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_CHECK = 3'd2,
    S_HINT  = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam logic [16*8:1] TXT_IDLE  = "ENTER NUMBER    ";
  localparam logic [16*8:1] TXT_ARMED = "GUESS NOW       ";
  localparam logic [16*8:1] TXT_CHECK = "CHECKING        ";
  localparam logic [16*8:1] TXT_WIN   = "YOU WIN         ";
  localparam logic [16*8:1] TXT_LOSE  = "GAME OVER       ";
`ifdef GUESS_HINT_EN
  localparam logic [16*8:1] TXT_HIGH  = "TOO HIGH        ";
  localparam logic [16*8:1] TXT_LOW   = "TOO LOW         ";
`else
  localparam logic [16*8:1] TXT_WRONG = "WRONG           ";
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] secret_q, secret_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] counter_q;
  logic [3:0]       attempts_q, attempts_d;
  logic             submit_n_prev_q, submit_m_prev_q, button_prev_q;
  logic [16*8:1]    string_q, string_d;
  logic             win_q, lose_q;
`ifdef GUESS_HINT_EN
  logic             hint_high_q, hint_high_d;
`endif

  logic             press_n_s, press_m_s, press_btn_s, entry_valid_s;
  logic [3:0]       attempts_dec_s;
  logic             guess_match_s;

  // A press is a one-cycle falling edge against the registered history.
  assign press_n_s      = submit_n_prev_q & ~submit_N;
  assign press_m_s      = submit_m_prev_q & ~submit_M;
  assign press_btn_s    = button_prev_q   & ~button;
  assign entry_valid_s  = data_buffer[WIDTH];
  assign attempts_dec_s = attempts_q - 4'd1;
  assign guess_match_s  = (guess_q == secret_q);

  always_comb begin
    state_d    = state_q;
    secret_d   = secret_q;
    guess_d    = guess_q;
    attempts_d = attempts_q;
`ifdef GUESS_HINT_EN
    hint_high_d = hint_high_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (press_btn_s) begin
          state_d = S_IDLE;
        end else if (press_n_s && entry_valid_s) begin
          state_d    = S_ARMED;
          attempts_d = (timesIN == 4'd0) ? 4'd1 : timesIN;
          if (mode) begin
            secret_d = data_buffer[WIDTH-1:0];
          end else begin
            secret_d = counter_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED, S_HINT: begin
        if (press_btn_s) begin
          state_d = S_IDLE;
        end else if (press_m_s && entry_valid_s) begin
          state_d = S_CHECK;
          guess_d = data_buffer[WIDTH-1:0];
        end else begin
          state_d = state_q;
        end
      end
      // All presses are dropped here; the result lands one cycle after the guess.
      S_CHECK: begin
        attempts_d = attempts_dec_s;
        if (guess_match_s) begin
          state_d = S_WIN;
        end else if (attempts_dec_s == 4'd0) begin
          state_d = S_LOSE;
        end else begin
          state_d = S_HINT;
`ifdef GUESS_HINT_EN
          hint_high_d = (guess_q > secret_q);
`endif
        end
      end
      S_WIN, S_LOSE: begin
        if (press_btn_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    string_d = TXT_IDLE;
    case (state_d)
      S_IDLE:  string_d = TXT_IDLE;
      S_ARMED: string_d = TXT_ARMED;
      S_CHECK: string_d = TXT_CHECK;
      S_HINT: begin
`ifdef GUESS_HINT_EN
        if (hint_high_d) begin
          string_d = TXT_HIGH;
        end else begin
          string_d = TXT_LOW;
        end
`else
        string_d = TXT_WRONG;
`endif
      end
      S_WIN:   string_d = TXT_WIN;
      S_LOSE:  string_d = TXT_LOSE;
      default: string_d = TXT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      secret_q        <= '0;
      guess_q         <= '0;
      counter_q       <= '0;
      attempts_q      <= 4'd0;
      submit_n_prev_q <= 1'b1;
      submit_m_prev_q <= 1'b1;
      button_prev_q   <= 1'b1;
      string_q        <= TXT_IDLE;
      win_q           <= 1'b0;
      lose_q          <= 1'b0;
`ifdef GUESS_HINT_EN
      hint_high_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      secret_q        <= secret_d;
      guess_q         <= guess_d;
      counter_q       <= counter_q + WIDTH'(1);
      attempts_q      <= attempts_d;
      submit_n_prev_q <= submit_N;
      submit_m_prev_q <= submit_M;
      button_prev_q   <= button;
      string_q        <= string_d;
      win_q           <= (state_d == S_WIN);
      lose_q          <= (state_d == S_LOSE);
`ifdef GUESS_HINT_EN
      hint_high_q     <= hint_high_d;
`endif
    end
  end

  assign string_o      = string_q;
  assign state         = state_q;
  assign attempts_left = attempts_q;
  assign win           = win_q;
  assign lose          = lose_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed self-checking bench for guess_round_ctrl; expected hint text follows GUESS_HINT_EN.
module tb_guess_round_ctrl;

  logic          clk, reset, mode, submit_N, submit_M, button;
  logic [3:0]    timesIN;
  logic [16:0]   data_buffer;
  logic [16*8:1] string_o;
  logic [2:0]    state;
  logic [3:0]    attempts_left;
  logic          win, lose;

  int checks = 0;
  int fails  = 0;

  localparam logic [16*8:1] EXP_IDLE  = "ENTER NUMBER    ";
  localparam logic [16*8:1] EXP_ARMED = "GUESS NOW       ";
  localparam logic [16*8:1] EXP_CHECK = "CHECKING        ";
  localparam logic [16*8:1] EXP_WIN   = "YOU WIN         ";
  localparam logic [16*8:1] EXP_LOSE  = "GAME OVER       ";
`ifdef GUESS_HINT_EN
  localparam logic [16*8:1] EXP_HIGH  = "TOO HIGH        ";
  localparam logic [16*8:1] EXP_LOW   = "TOO LOW         ";
`else
  localparam logic [16*8:1] EXP_HIGH  = "WRONG           ";
  localparam logic [16*8:1] EXP_LOW   = "WRONG           ";
`endif

  guess_round_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mode(mode), .submit_N(submit_N), .submit_M(submit_M),
    .button(button), .timesIN(timesIN), .data_buffer(data_buffer), .string_o(string_o),
    .state(state), .attempts_left(attempts_left), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_n(input logic [16:0] db, input logic [3:0] t);
    data_buffer = db; timesIN = t; submit_N = 1'b0;
    tick();
    submit_N = 1'b1;
  endtask

  task automatic press_m(input logic [16:0] db);
    data_buffer = db; submit_M = 1'b0;
    tick();
    submit_M = 1'b1;
  endtask

  task automatic press_btn();
    button = 1'b0;
    tick();
    button = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (string_o !== EXP_IDLE) begin fails++; $display("FAIL reset_string: got '%s' expected '%s'", string_o, EXP_IDLE); end
    checks++; if (attempts_left !== 4'd0 || win !== 1'b0 || lose !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got att=%0d win=%0b lose=%0b expected 0/0/0", attempts_left, win, lose); end
  endtask

  task automatic test_full_game();
    mode = 1'b1;
    press_n(17'h10010, 4'd5);
    checks++; if (state !== 3'd1 || attempts_left !== 4'd5) begin fails++; $display("FAIL full_armed: got st=%0d att=%0d expected 1/5", state, attempts_left); end
    checks++; if (string_o !== EXP_ARMED) begin fails++; $display("FAIL full_armed_str: got '%s' expected '%s'", string_o, EXP_ARMED); end
    press_m(17'h10015);
    checks++; if (state !== 3'd2 || attempts_left !== 4'd5 || string_o !== EXP_CHECK) begin
      fails++; $display("FAIL full_check: got st=%0d att=%0d str='%s' expected 2/5/'%s'", state, attempts_left, string_o, EXP_CHECK); end
    tick();
    checks++; if (state !== 3'd3 || attempts_left !== 4'd4) begin fails++; $display("FAIL full_hint1: got st=%0d att=%0d expected 3/4", state, attempts_left); end
    checks++; if (string_o !== EXP_HIGH) begin fails++; $display("FAIL full_hint1_str: got '%s' expected '%s'", string_o, EXP_HIGH); end
    press_m(17'h10007); tick();
    checks++; if (state !== 3'd3 || attempts_left !== 4'd3) begin fails++; $display("FAIL full_hint2: got st=%0d att=%0d expected 3/3", state, attempts_left); end
    checks++; if (string_o !== EXP_LOW) begin fails++; $display("FAIL full_hint2_str: got '%s' expected '%s'", string_o, EXP_LOW); end
    press_m(17'h10010); tick();
    checks++; if (state !== 3'd4 || attempts_left !== 4'd2 || win !== 1'b1 || lose !== 1'b0) begin
      fails++; $display("FAIL full_win: got st=%0d att=%0d win=%0b lose=%0b expected 4/2/1/0", state, attempts_left, win, lose); end
    checks++; if (string_o !== EXP_WIN) begin fails++; $display("FAIL full_win_str: got '%s' expected '%s'", string_o, EXP_WIN); end
    press_btn();
    checks++; if (state !== 3'd0 || win !== 1'b0 || string_o !== EXP_IDLE) begin
      fails++; $display("FAIL full_back_idle: got st=%0d win=%0b expected 0/0", state, win); end
  endtask

  task automatic test_budget();
    press_n(17'h10010, 4'd2);
    press_m(17'h10001); tick();
    checks++; if (state !== 3'd3 || attempts_left !== 4'd1) begin fails++; $display("FAIL budget_hint: got st=%0d att=%0d expected 3/1", state, attempts_left); end
    press_m(17'h10002); tick();
    checks++; if (state !== 3'd5 || lose !== 1'b1 || win !== 1'b0 || attempts_left !== 4'd0) begin
      fails++; $display("FAIL budget_lose: got st=%0d lose=%0b win=%0b att=%0d expected 5/1/0/0", state, lose, win, attempts_left); end
    checks++; if (string_o !== EXP_LOSE) begin fails++; $display("FAIL budget_lose_str: got '%s' expected '%s'", string_o, EXP_LOSE); end
    press_m(17'h10010); tick();
    checks++; if (state !== 3'd5 || attempts_left !== 4'd0) begin fails++; $display("FAIL budget_extra_guess: got st=%0d att=%0d expected 5/0", state, attempts_left); end
    press_btn();
    checks++; if (state !== 3'd0 || lose !== 1'b0) begin fails++; $display("FAIL budget_btn_idle: got st=%0d lose=%0b expected 0/0", state, lose); end
  endtask

  task automatic test_invalid_clamp();
    press_n(17'h00010, 4'd3); tick();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL invalid_secret: got st=%0d expected 0", state); end
    press_n(17'h10020, 4'd0);
    checks++; if (state !== 3'd1 || attempts_left !== 4'd1) begin fails++; $display("FAIL clamp_budget: got st=%0d att=%0d expected 1/1", state, attempts_left); end
    press_m(17'h00020); tick();
    checks++; if (state !== 3'd1) begin fails++; $display("FAIL invalid_guess: got st=%0d expected 1", state); end
    press_m(17'h10001); tick();
    checks++; if (state !== 3'd5 || attempts_left !== 4'd0) begin fails++; $display("FAIL clamp_lose: got st=%0d att=%0d expected 5/0", state, attempts_left); end
    press_btn();
  endtask

  task automatic test_press_handling();
    press_n(17'h10010, 4'd5);
    data_buffer = 17'h10001; submit_M = 1'b0;
    tick();
    checks++; if (state !== 3'd2) begin fails++; $display("FAIL hold_check: got st=%0d expected 2", state); end
    repeat (9) tick();
    checks++; if (state !== 3'd3 || attempts_left !== 4'd4) begin fails++; $display("FAIL hold_single: got st=%0d att=%0d expected 3/4", state, attempts_left); end
    submit_M = 1'b1; tick();
    press_m(17'h10002);
    button = 1'b0; submit_M = 1'b0;
    tick();
    checks++; if (state !== 3'd3 || attempts_left !== 4'd3) begin fails++; $display("FAIL check_drops: got st=%0d att=%0d expected 3/3", state, attempts_left); end
    button = 1'b1; submit_M = 1'b1; tick();
    checks++; if (state !== 3'd3 || attempts_left !== 4'd3) begin fails++; $display("FAIL release_no_press: got st=%0d att=%0d expected 3/3", state, attempts_left); end
    press_btn();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL hint_abandon: got st=%0d expected 0", state); end
    press_n(17'h10010, 4'd5);
    data_buffer = 17'h10010; button = 1'b0; submit_M = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || attempts_left !== 4'd5) begin fails++; $display("FAIL btn_over_guess: got st=%0d att=%0d expected 0/5", state, attempts_left); end
    button = 1'b1; submit_M = 1'b1; tick();
  endtask

  task automatic test_reset_mid_round();
    press_n(17'h10010, 4'd5);
    press_m(17'h10015); tick();
    checks++; if (state !== 3'd3) begin fails++; $display("FAIL mid_pre_hint: got st=%0d expected 3", state); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (state !== 3'd0 || attempts_left !== 4'd0 || string_o !== EXP_IDLE) begin
      fails++; $display("FAIL mid_reset: got st=%0d att=%0d str='%s' expected 0/0/'%s'", state, attempts_left, string_o, EXP_IDLE); end
  endtask

  task automatic test_counter_secret();
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 1'b0; data_buffer = 17'h1ABCD; timesIN = 4'd3;
    tick(); tick();
    submit_N = 1'b0; tick(); submit_N = 1'b1;
    checks++; if (state !== 3'd1 || attempts_left !== 4'd3) begin fails++; $display("FAIL ctr_armed: got st=%0d att=%0d expected 1/3", state, attempts_left); end
    press_m(17'h10001); tick();
    checks++; if (state !== 3'd3 || string_o !== EXP_LOW) begin fails++; $display("FAIL ctr_low: got st=%0d str='%s' expected 3/'%s'", state, string_o, EXP_LOW); end
    press_m(17'h10002); tick();
    checks++; if (state !== 3'd4 || attempts_left !== 4'd1 || win !== 1'b1) begin
      fails++; $display("FAIL ctr_win: got st=%0d att=%0d win=%0b expected 4/1/1", state, attempts_left, win); end
    press_btn();
    mode = 1'b1;
  endtask

  task automatic test_last_attempt_win();
    press_n(17'h10033, 4'd1);
    press_m(17'h10033); tick();
    checks++; if (state !== 3'd4 || attempts_left !== 4'd0 || win !== 1'b1 || lose !== 1'b0) begin
      fails++; $display("FAIL last_win: got st=%0d att=%0d win=%0b lose=%0b expected 4/0/1/0", state, attempts_left, win, lose); end
    press_btn();
  endtask

  initial begin
    reset = 1'b1; mode = 1'b1; submit_N = 1'b1; submit_M = 1'b1; button = 1'b1;
    timesIN = 4'd0; data_buffer = 17'h00000;
    test_reset();
    test_full_game();
    test_budget();
    test_invalid_clamp();
    test_press_handling();
    test_reset_mid_round();
    test_counter_secret();
    test_last_attempt_win();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
